// File: rtl/seg_debug_display.sv
// ----------------------------------------------------------------------------
// seg_debug_display
//
// Shows one of the core's four 32-bit debug words as 8 hex digits on a
// common-anode 7-segment display. The display is time-multiplexed.
//   - The chosen word is captured once per frame, at the start of digit 0.
//     A frame that is already being scanned never changes (no tearing).
//   - Each digit slot lasts SCAN_CYCLES clocks. The first clock of every
//     slot is blank (all anodes off), so the previous digit's segments do
//     not ghost onto the next digit.
//   - Runs on the raw board clock.
//
// Ports:
//   clk        board clock
//   rst        synchronous active-high reset
//   dbg0..3    debug words (PC, data address, instruction, debug register)
//   sel        word select, 0..3 -> dbg0..dbg3
//   hold       1 = keep the current snapshot; also lights dp on digit 0
//   an         active-low anode enables, an[i] = digit i (0 = rightmost)
//   seg        active-low segments {dp,g,f,e,d,c,b,a}
//   frame_done one-cycle pulse at the last cycle of each 8-digit frame
//   shown      snapshot word, registered copy for LEDs / observation
//
// Optional feature (macro SEG_LEADING_ZERO_BLANK_EN):
//   When defined, digits above the most significant non-zero nibble are
//   shown dark (seg[6:0] = 7F). The anodes still scan normally, so the
//   timing does not change. Digit 0 is always shown.
// ----------------------------------------------------------------------------
module seg_debug_display #(
  parameter int SCAN_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dbg0,
  input  logic [31:0] dbg1,
  input  logic [31:0] dbg2,
  input  logic [31:0] dbg3,
  input  logic [1:0]  sel,
  input  logic        hold,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_done,
  output logic [31:0] shown
);

  localparam int CW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_CYCLES - 1);

  // Active-low 7-segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'h0: r = 7'h40;
      4'h1: r = 7'h79;
      4'h2: r = 7'h24;
      4'h3: r = 7'h30;
      4'h4: r = 7'h19;
      4'h5: r = 7'h12;
      4'h6: r = 7'h02;
      4'h7: r = 7'h78;
      4'h8: r = 7'h00;
      4'h9: r = 7'h10;
      4'hA: r = 7'h08;
      4'hB: r = 7'h03;
      4'hC: r = 7'h46;
      4'hD: r = 7'h21;
      4'hE: r = 7'h06;
      default: r = 7'h0E;
    endcase
    return r;
  endfunction

  // State
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   word_q, word_d;

  // Registered outputs
  logic [7:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic          frame_done_q, frame_done_d;
  logic [31:0]   shown_q, shown_d;

  // Combinational helpers
  logic          cnt_last;
  logic          frame_start;
  logic [31:0]   dbg_sel;
  logic [4:0]    nib_lsb;
  logic [3:0]    nibble;
  logic          lead_blank;
  logic [6:0]    glyph;

  // Scan counters and snapshot
  always_comb begin
    cnt_last    = (cnt_q == CNT_MAX);
    cnt_d       = cnt_last ? '0 : cnt_q + CW'(1);
    idx_d       = cnt_last ? idx_q + 3'd1 : idx_q;
    frame_start = (cnt_q == '0) && (idx_q == 3'd0);

    case (sel)
      2'd0:    dbg_sel = dbg0;
      2'd1:    dbg_sel = dbg1;
      2'd2:    dbg_sel = dbg2;
      default: dbg_sel = dbg3;
    endcase

    // The word is captured only at the start of a frame, so changes to
    // sel or dbg during a scan cannot tear the digits already showing.
    word_d = word_q;
    if (frame_start && !hold)
      word_d = dbg_sel;
  end

  // Digit decode
  always_comb begin
    nib_lsb = {idx_q, 2'b00};
    nibble  = word_q[nib_lsb +: 4];

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // The digit is a leading zero when this nibble and every nibble above
    // it are zero. Digit 0 is always shown, so a zero word displays "0".
    lead_blank = (idx_q != 3'd0) && ((word_q >> nib_lsb) == 32'd0);
`else
    lead_blank = 1'b0;
`endif

    glyph = lead_blank ? 7'h7F : hex7(nibble);
  end

  // Output stage, registered from the current (cnt, idx, word) state
  always_comb begin
    an_d         = 8'hFF;
    seg_d        = 8'hFF;
    frame_done_d = cnt_last && (idx_q == 3'd7);
    shown_d      = word_q;

    // cnt == 0 is the blank slot between digits.
    if (cnt_q != '0) begin
      an_d       = ~(8'h01 << idx_q);
      seg_d[6:0] = glyph;
      // dp on the rightmost digit marks a frozen snapshot.
      seg_d[7]   = ~((idx_q == 3'd0) && hold);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      word_q       <= 32'd0;
      an_q         <= 8'hFF;
      seg_q        <= 8'hFF;
      frame_done_q <= 1'b0;
      shown_q      <= 32'd0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
      shown_q      <= shown_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;
  assign shown      = shown_q;

endmodule

// File: tb/tb_seg_debug_display.sv
// ----------------------------------------------------------------------------
// Testbench for seg_debug_display, run with SCAN_CYCLES = 4 (32-cycle frames).
// Each step in the stimulus pushes the digit slots it expects into a queue.
// A monitor pops one entry for every lit cycle and compares it with the DUT.
// Time n is the n-th clock edge after a reset release.
// ----------------------------------------------------------------------------
module tb_seg_debug_display;

  localparam int SC    = 4;
  localparam int FRAME = 8 * SC;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dbg0, dbg1, dbg2, dbg3;
  logic [1:0]  sel;
  logic        hold;
  logic [7:0]  an, seg;
  logic        frame_done;
  logic [31:0] shown;

  always #5 clk = ~clk;

  seg_debug_display #(.SCAN_CYCLES(SC)) dut (
    .clk(clk), .rst(rst),
    .dbg0(dbg0), .dbg1(dbg1), .dbg2(dbg2), .dbg3(dbg3),
    .sel(sel), .hold(hold),
    .an(an), .seg(seg), .frame_done(frame_done), .shown(shown)
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [15:0] exp_q[$];
  bit          mon_en = 1'b0;
  int          cyc = 0;
  int          fd_cnt = 0;
  int          fd_last = -1;
  int          now = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [6:0] hexseg(input logic [3:0] v);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[v];
  endfunction

  function automatic logic [7:0] exp_seg(input logic [31:0] w, input int d, input bit dp);
    logic [31:0] sh;
    logic [7:0]  r;
    sh = w >> (4 * d);
    r  = {~dp, hexseg(sh[3:0])};
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (d != 0 && sh == 32'd0) r[6:0] = 7'h7F;
`endif
    return r;
  endfunction

  // Queue the lit cycles of digits 0..nd-1 for word w. The last digit
  // gets last_reps cycles, so a frame cut short by reset can be expressed.
  task automatic push_digits(input logic [31:0] w, input bit dp, input int nd, input int last_reps);
    logic [7:0] a;
    int reps;
    for (int d = 0; d < nd; d++) begin
      a    = 8'h01 << d;
      a    = ~a;
      reps = (d == nd - 1) ? last_reps : SC - 1;
      for (int r = 0; r < reps; r++)
        exp_q.push_back({a, exp_seg(w, d, dp && (d == 0))});
    end
  endtask

  task automatic push_frame(input logic [31:0] w, input bit dp);
    push_digits(w, dp, 8, SC - 1);
  endtask

  // Advance to the falling edge right after edge n.
  task automatic step_to(input int n);
    while (now < n + 1) begin
      @(negedge clk);
      now++;
    end
  endtask

  // Monitor: compares every displayed cycle against the queue, and
  // checks that the frame_done pulses are spaced one frame apart.
  always @(negedge clk) begin
    logic [15:0] e;
    if (mon_en) begin
      cyc++;
      if (an !== 8'hFF) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_digit: got an=%h seg=%h, expected none", an, seg);
        end else begin
          e = exp_q.pop_front();
          check("digit", {16'h0, an, seg}, {16'h0, e});
        end
      end else begin
        check("blank_seg", {24'h0, seg}, 32'h0000_00FF);
      end
      if (frame_done === 1'b1) begin
        fd_cnt++;
        if (fd_last >= 0) check("frame_period", cyc - fd_last, FRAME);
        fd_last = cyc;
      end
    end
  end

  initial begin
    rst  = 1'b1;
    dbg0 = 32'h1234ABCD;
    dbg1 = 32'h0;
    dbg2 = 32'hDEADBEEF;
    dbg3 = 32'h0;
    sel  = 2'd0;
    hold = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_an", {24'h0, an}, 32'hFF);
    check("rst_seg", {24'h0, seg}, 32'hFF);
    check("rst_frame_done", {31'h0, frame_done}, 32'h0);
    check("rst_shown", shown, 32'h0);

    // Release reset. Frame 0 shows dbg0, which is captured at edge 0.
    rst    = 1'b0;
    mon_en = 1'b1;
    now    = 0;
    push_frame(32'h1234ABCD, 1'b0);

    step_to(0); check("first_out_blank", {24'h0, an}, 32'hFF);
    step_to(1); check("digit0_an", {24'h0, an}, 32'hFE);
    step_to(4); check("slot1_blank", {24'h0, an}, 32'hFF);
    step_to(5); check("digit1_an", {24'h0, an}, 32'hFD);
    step_to(16); check("shown_f0", shown, 32'h1234ABCD);
    push_frame(32'h1234ABCD, 1'b0);

    // Change sel during digit 3 of frame 1. The new word appears only in frame 2.
    step_to(FRAME + 13);
    sel = 2'd2;
    push_frame(32'hDEADBEEF, 1'b0);

    step_to(2 * FRAME + 16); check("shown_f2", shown, 32'hDEADBEEF);
    sel = 2'd0;
    push_frame(32'h1234ABCD, 1'b0);

    // Set hold in frame 3 after digit 0, then clear dbg0. Frames 4-6 keep
    // the held word and light dp on digit 0.
    step_to(3 * FRAME + 16); check("shown_f3", shown, 32'h1234ABCD);
    hold = 1'b1;
    dbg0 = 32'h0;
    push_frame(32'h1234ABCD, 1'b1);
    push_frame(32'h1234ABCD, 1'b1);
    push_frame(32'h1234ABCD, 1'b1);

    step_to(4 * FRAME + 16); check("shown_hold_f4", shown, 32'h1234ABCD);
    step_to(5 * FRAME + 16); check("shown_hold_f5", shown, 32'h1234ABCD);
    step_to(6 * FRAME + 16); check("shown_hold_f6", shown, 32'h1234ABCD);
    hold = 1'b0;
    push_frame(32'h0, 1'b0);

    step_to(7 * FRAME + 16); check("shown_released", shown, 32'h0);
    dbg0 = 32'h000000A0;
    // Frame 8 is cut short by reset: digits 0-4 run in full, digit 5 shows one lit cycle.
    push_digits(32'h000000A0, 1'b0, 6, 1);

    // Reset is sampled when idx=5 and cnt=2 (edge 8*FRAME+22).
    step_to(8 * FRAME + 21);
    rst = 1'b1;
    step_to(8 * FRAME + 22);
    check("midrst_an", {24'h0, an}, 32'hFF);
    check("midrst_seg", {24'h0, seg}, 32'hFF);
    check("midrst_shown", shown, 32'h0);
    fd_last = -1;

    rst = 1'b0;
    now = 0;
    push_frame(32'h000000A0, 1'b0);
    step_to(0); check("rerelease_blank", {24'h0, an}, 32'hFF);
    step_to(16); check("shown_after_rst", shown, 32'h000000A0);
    dbg0 = 32'h0;
    push_frame(32'h0, 1'b0);
    step_to(FRAME + 16); check("shown_zero", shown, 32'h0);

    step_to(2 * FRAME);
    check("queue_drained", exp_q.size(), 0);
    check("frame_done_count", fd_cnt, 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
